// File: rtl/div_unit.sv
// div_unit: multi-cycle signed divide / remainder (radix-2 restoring, WIDTH iterations).
// Optional feature macro: DIV_EARLY_OUT_EN -- when defined, divide-by-zero and the
// MIN/-1 overflow case finish on the accept edge and go straight to DONE.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       aluControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam logic [4:0]  OP_DIV = 5'b00011;
  localparam logic [4:0]  OP_MOD = 5'b00100;
  localparam int unsigned CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, next_state;
  logic             busy_nxt, done_nxt;
  logic             accept;
  logic             special;
  logic [WIDTH-1:0] early_res;

  logic             op_mod, neg_q, neg_r, bzero;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo, dvs;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Operation accept and operand magnitudes (MIN maps to itself as an unsigned magnitude)
  always_comb begin
    accept = ((state == IDLE) || (state == DONE)) && start &&
             ((aluControl == OP_DIV) || (aluControl == OP_MOD));
    a_mag  = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    b_mag  = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
  end

`ifdef DIV_EARLY_OUT_EN
  // Special-case detection and result for the single-cycle path
  always_comb begin
    special   = 1'b0;
    early_res = '0;
    if (B == '0) begin
      special   = 1'b1;
      early_res = (aluControl == OP_MOD) ? A : '1;
    end else if ((A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1)) begin
      special   = 1'b1;
      early_res = (aluControl == OP_MOD) ? '0 : A;
    end
  end
`else
  // Every operation runs the full iterative datapath
  always_comb begin
    special   = 1'b0;
    early_res = '0;
  end
`endif

  // One restoring iteration plus the sign fix-up of the final quotient/remainder
  always_comb begin
    shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    ge      = (shifted >= {1'b0, dvs});
    q_fix   = neg_q ? (~quo + WIDTH'(1)) : quo;
    r_fix   = neg_r ? (~rem[WIDTH-1:0] + WIDTH'(1)) : rem[WIDTH-1:0];
  end

  // State register with registered busy/done
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        next_state = IDLE;
        if (accept) next_state = special ? DONE : CALC;
      end
      CALC:    if (count == CW'(WIDTH - 1)) next_state = FIX;
      FIX:     next_state = DONE;
      default: next_state = IDLE;
    endcase
    busy_nxt = (next_state == CALC) || (next_state == FIX);
    done_nxt = (next_state == DONE);
  end

  // Datapath: operand capture, iteration, result write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      op_mod      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      bzero       <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      count       <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_mod <= (aluControl == OP_MOD);
      neg_r  <= A[WIDTH-1];
      neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
      bzero  <= (B == '0);
      rem    <= '0;
      quo    <= a_mag;
      dvs    <= b_mag;
      count  <= '0;
      if (special) begin
        result      <= early_res;
        div_by_zero <= (B == '0);
      end
    end else if (state == CALC) begin
      rem   <= ge ? diff : shifted;
      quo   <= {quo[WIDTH-2:0], ge};
      count <= count + CW'(1);
    end else if (state == FIX) begin
      // Divide-by-zero quotient is forced to all ones; remainder is naturally A
      result      <= op_mod ? r_fix : (bzero ? '1 : q_fix);
      div_by_zero <= bzero;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at accept time and
// compared when done pulses, together with the done latency and per-cycle busy.
module tb_div_unit;

  localparam int unsigned W = 32;
  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_MOD = 5'b00100;
  localparam logic [31:0] MINV  = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [4:0]    aluControl;
  logic [W-1:0]  A, B;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  result;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          n;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .aluControl(aluControl),
    .A(A), .B(B), .busy(busy), .done(done), .result(result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: truncating signed divide, remainder follows the dividend
  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return (op == OP_MOD) ? a : 32'hFFFF_FFFF;
    if (a == MINV && b == 32'hFFFF_FFFF) return (op == OP_MOD) ? 32'd0 : MINV;
    return (op == OP_MOD) ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'd0 || (a == MINV && b == 32'hFFFF_FFFF)) return 1;
`endif
    return W + 2;
  endfunction

  // Drive a request in the current cycle; push an expectation if it will be accepted
  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_accept);
    exp_t e;
    start      = 1'b1;
    aluControl = op;
    A          = a;
    B          = b;
    if (expect_accept) begin
      e.res = ref_res(op, a, b);
      e.dbz = (b == 32'd0);
      e.n   = cyc;
      e.lat = ref_lat(a, b);
      q.push_back(e);
    end
  endtask

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); #1;
    drive(op, a, b, 1'b1);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 80) begin
      @(negedge clk); #1;
      k++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  // Monitor: result scoreboard, done latency and busy window
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_busy;
      exp_busy = 1'b0;
      if (q.size() != 0)
        exp_busy = (q[0].lat > 1) && (cyc >= q[0].n + 1) && (cyc <= q[0].n + q[0].lat - 1);
      check("busy", 64'(busy), 64'(exp_busy));
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", 64'(result), 64'(e.res));
          check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          check("done_cycle", 64'(cyc), 64'(e.n + e.lat));
        end
      end else if (q.size() != 0 && cyc > q[0].n + q[0].lat) begin
        check("done_missing", 64'(done), 64'd1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; aluControl = 5'd0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    #1 mon_en = 1'b1;

    do_op(OP_DIV, 32'd100, 32'd7);                 wait_drain();
    do_op(OP_MOD, 32'hFFFF_FFF9, 32'd2);           wait_drain();
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);           wait_drain();
    do_op(OP_DIV, 32'd5, 32'd0);                   wait_drain();
    do_op(OP_MOD, 32'd5, 32'd0);                   wait_drain();
    do_op(OP_DIV, MINV, 32'hFFFF_FFFF);            wait_drain();
    do_op(OP_MOD, MINV, 32'hFFFF_FFFF);            wait_drain();
    do_op(OP_MOD, 32'hFFFF_FFF0, 32'd0);           wait_drain();

    // Start during CALC (cycle N+5) with new operands must be ignored
    do_op(OP_DIV, 32'd1000, 32'hFFFF_FFFD);
    repeat (4) @(negedge clk);
    #1 drive(OP_MOD, 32'd1, 32'd1, 1'b0);
    @(negedge clk); #1 start = 1'b0;

    // Start in the DONE cycle is accepted back-to-back
    k = 0;
    while (!done && k < 60) begin @(negedge clk); k++; end
    check("b2b_done_seen", 64'(done), 64'd1);
    #1 drive(OP_MOD, 32'd12345, 32'd100, 1'b1);
    @(negedge clk); #1 start = 1'b0;
    wait_drain();

    // Reset mid-CALC discards the operation
    do_op(OP_DIV, 32'd77, 32'd3);
    repeat (8) @(negedge clk);
    #1 reset = 1'b1;
    q.delete();
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_dbz", 64'(div_by_zero), 64'd0);
    #1 reset = 1'b0;
    repeat (40) @(negedge clk);

    // Unsupported aluControl is ignored
    @(negedge clk); #1 drive(5'b00000, 32'd9, 32'd3, 1'b0);
    @(negedge clk); #1 start = 1'b0;
    check("badop_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);

    // Random signed operands
    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($signed(8'($urandom))) : $urandom;
      do_op((i % 2 == 0) ? OP_DIV : OP_MOD, ra, rb);
      wait_drain();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
